// File: rtl/rw_access_sequencer_pkg.sv
// rw_seq_pkg: shared state encoding and counter widths for the access sequencer.
package rw_seq_pkg;
    typedef enum logic [2:0] {IDLE, WRITE, TURN, READ, DONE} rw_state_t;
    localparam int BEAT_CNT_W = 4;
    localparam int TURN_CNT_W = 3;
    localparam int TMO_CNT_W = 8;
endpackage

// File: rtl/rw_access_sequencer_if.sv
// rw_access_sequencer_if: control request, memory-port strobes and status of one sequencer.
interface rw_access_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic start, wr, rd, ack, busy, done, err;
    logic [ADDR_W-1:0] base_addr, addr;
    logic [DATA_W-1:0] seed, wdata, rdata;
    modport master (
        input  start, base_addr, seed, rdata, ack,
        output wr, rd, addr, wdata, busy, done, err
    );
    modport slave (
        output start, base_addr, seed, rdata, ack,
        input  wr, rd, addr, wdata, busy, done, err
    );
endinterface

// File: rtl/rw_beat_timer.sv
// rw_beat_timer: counts ack-less cycles of the current beat and flags the one that hits TIMEOUT.
module rw_beat_timer
    import rw_seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [TMO_CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst || clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 1'b1;
    end
    // Fires in the cycle whose increment would reach TIMEOUT, so the strobe drops right after.
    assign expired_o = en_i && (cnt_q == TMO_CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/rw_access_sequencer.sv
// rw_access_sequencer: start-triggered write burst, optional turnaround gap, then read-back check.
module rw_access_sequencer
    import rw_seq_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int WR_BEATS = 1,
    parameter int RD_BEATS = 2,
    parameter int TURN_CYC = 0,
    parameter int TIMEOUT  = 15
) (
    input logic clk,
    input logic rst,
    rw_access_sequencer_if.master bus
);
    localparam logic [BEAT_CNT_W-1:0] W_LAST = BEAT_CNT_W'(WR_BEATS - 1);
    localparam logic [BEAT_CNT_W-1:0] R_LAST = BEAT_CNT_W'(RD_BEATS - 1);
    localparam logic [TURN_CNT_W-1:0] T_LAST = TURN_CNT_W'(TURN_CYC - 1);
    rw_state_t state_q;
    logic start_q, wr_q, rd_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0] addr_q, base_q;
    logic [DATA_W-1:0] wdata_q, seed_q;
    logic [BEAT_CNT_W-1:0] beat_q, ridx_q, beat_d, ridx_d;
    logic [TURN_CNT_W-1:0] turn_q;
    logic rise, in_beat, expired;
    assign rise = bus.start & ~start_q;
    assign in_beat = (state_q == WRITE) || (state_q == READ);
    assign beat_d = beat_q + 1'b1;
    // Reads cycle through the written addresses when RD_BEATS exceeds WR_BEATS.
    assign ridx_d = (ridx_q == W_LAST) ? '0 : ridx_q + 1'b1;
    rw_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (~in_beat | bus.ack),
        .en_i     (in_beat & ~bus.ack),
        .expired_o(expired)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            base_q  <= '0;
            seed_q  <= '0;
            beat_q  <= '0;
            ridx_q  <= '0;
            turn_q  <= '0;
        end else begin
            start_q <= bus.start;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: if (rise) begin
                    state_q <= WRITE;
                    base_q  <= bus.base_addr;
                    seed_q  <= bus.seed;
                    addr_q  <= bus.base_addr;
                    wdata_q <= bus.seed;
                    beat_q  <= '0;
                    wr_q    <= 1'b1;
                    busy_q  <= 1'b1;
                    err_q   <= 1'b0;
                end
                WRITE: if (bus.ack) begin
                    if (beat_q == W_LAST) begin
                        state_q <= (TURN_CYC > 0) ? TURN : READ;
                        wr_q    <= 1'b0;
                        rd_q    <= (TURN_CYC == 0);
                        addr_q  <= base_q;
                        wdata_q <= '0;
                        beat_q  <= '0;
                        ridx_q  <= '0;
                        turn_q  <= '0;
                    end else begin
                        beat_q  <= beat_d;
                        addr_q  <= base_q + ADDR_W'(beat_d);
                        wdata_q <= seed_q + DATA_W'(beat_d);
                    end
                end else if (expired) begin
                    state_q <= DONE;
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                end
                TURN: if (turn_q == T_LAST) begin
                    state_q <= READ;
                    rd_q    <= 1'b1;
                end else begin
                    turn_q <= turn_q + 1'b1;
                end
                READ: if (bus.ack) begin
                    if (bus.rdata != seed_q + DATA_W'(ridx_q)) err_q <= 1'b1;
                    if (beat_q == R_LAST) begin
                        state_q <= DONE;
                        rd_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        beat_q <= beat_d;
                        ridx_q <= ridx_d;
                        addr_q <= base_q + ADDR_W'(ridx_d);
                    end
                end else if (expired) begin
                    state_q <= DONE;
                    rd_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.wr    = wr_q;
    assign bus.rd    = rd_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_rw_access_sequencer.sv
// tb_rw_access_sequencer: directed bursts on two sequencer configurations with a cycle-stamped scoreboard.
module tb_rw_access_sequencer;
    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;
    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_DONE = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ack_a = 1'b1;
    logic zero_a = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    rw_access_sequencer_if #(.ADDR_W(8), .DATA_W(8)) ba ();
    rw_access_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bb ();
    rw_access_sequencer #(
        .ADDR_W(8), .DATA_W(8), .WR_BEATS(1), .RD_BEATS(2), .TURN_CYC(0), .TIMEOUT(15)
    ) dut_a (.clk(clk), .rst(rst), .bus(ba));
    rw_access_sequencer #(
        .ADDR_W(8), .DATA_W(8), .WR_BEATS(3), .RD_BEATS(3), .TURN_CYC(2), .TIMEOUT(15)
    ) dut_b (.clk(clk), .rst(rst), .bus(bb));
    always @(posedge clk) begin
        if (ba.wr && ba.ack) mem_a[ba.addr] <= ba.wdata;
        if (bb.wr && bb.ack) mem_b[bb.addr] <= bb.wdata;
    end
    assign ba.ack   = ack_a;
    assign ba.rdata = zero_a ? 8'h00 : mem_a[ba.addr];
    assign bb.ack   = 1'b1;
    assign bb.rdata = mem_b[bb.addr];
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic push(input int g, input int kind, input int c, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        if (g == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask
    task automatic mon(input int g, input logic wr, input logic rd, input logic done, input logic err,
                       input logic [7:0] addr, input logic [7:0] wdata);
        exp_t e;
        int kind;
        if (wr && rd) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_wr_rd_exclusive: wr and rd both 1 (cycle %0d)", g, cyc);
        end
        if (!(wr || rd || done)) return;
        kind = wr ? K_WR : rd ? K_RD : K_DONE;
        if ((g == 0 && qa.size() == 0) || (g == 1 && qb.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_unexpected_output: kind %0d seen, none expected (cycle %0d)", g, kind, cyc);
            return;
        end
        if (g == 0) e = qa.pop_front();
        else e = qb.pop_front();
        chk($sformatf("dut%0d_kind", g), kind, e.kind);
        chk($sformatf("dut%0d_cycle", g), cyc, e.cyc);
        if (e.kind == K_DONE) begin
            chk($sformatf("dut%0d_done_err", g), int'(err), int'(e.data));
        end else begin
            chk($sformatf("dut%0d_addr", g), int'(addr), int'(e.addr));
            chk($sformatf("dut%0d_wdata", g), int'(wdata), int'(e.data));
        end
    endtask
    always @(negedge clk) begin
        mon(0, ba.wr, ba.rd, ba.done, ba.err, ba.addr, ba.wdata);
        mon(1, bb.wr, bb.rd, bb.done, bb.err, bb.addr, bb.wdata);
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic go(input int g, input logic [7:0] base, input logic [7:0] seed, output int s);
        s = cyc;
        if (g == 0) begin
            ba.start = 1'b1;
            ba.base_addr = base;
            ba.seed = seed;
        end else begin
            bb.start = 1'b1;
            bb.base_addr = base;
            bb.seed = seed;
        end
        tick(1);
        ba.start = 1'b0;
        bb.start = 1'b0;
    endtask
    initial begin
        int s;
        ba.start = 1'b0;
        ba.base_addr = '0;
        ba.seed = '0;
        bb.start = 1'b0;
        bb.base_addr = '0;
        bb.seed = '0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_wr", int'(ba.wr), 0);
        chk("reset_rd", int'(ba.rd), 0);
        chk("reset_busy", int'(ba.busy), 0);
        chk("reset_done", int'(ba.done), 0);
        chk("reset_err", int'(ba.err), 0);
        chk("reset_addr", int'(ba.addr), 0);
        chk("reset_wdata", int'(ba.wdata), 0);
        tick(1);
        // Single write, two read-backs, ack always high.
        go(0, 8'h10, 8'hA5, s);
        push(0, K_WR, s + 1, 8'h10, 8'hA5);
        push(0, K_RD, s + 2, 8'h10, 8'h00);
        push(0, K_RD, s + 3, 8'h10, 8'h00);
        push(0, K_DONE, s + 4, 8'h00, 8'h00);
        @(negedge clk);
        chk("busy_first_write", int'(ba.busy), 1);
        tick(8);
        // Three beats wrapping the address/data space, two turnaround cycles.
        go(1, 8'hFE, 8'hFF, s);
        push(1, K_WR, s + 1, 8'hFE, 8'hFF);
        push(1, K_WR, s + 2, 8'hFF, 8'h00);
        push(1, K_WR, s + 3, 8'h00, 8'h01);
        push(1, K_RD, s + 6, 8'hFE, 8'h00);
        push(1, K_RD, s + 7, 8'hFF, 8'h00);
        push(1, K_RD, s + 8, 8'h00, 8'h00);
        push(1, K_DONE, s + 9, 8'h00, 8'h00);
        tick(12);
        // Read data forced to zero: mismatch, sticky err.
        zero_a = 1'b1;
        go(0, 8'h20, 8'hA5, s);
        push(0, K_WR, s + 1, 8'h20, 8'hA5);
        push(0, K_RD, s + 2, 8'h20, 8'h00);
        push(0, K_RD, s + 3, 8'h20, 8'h00);
        push(0, K_DONE, s + 4, 8'h00, 8'h01);
        tick(8);
        zero_a = 1'b0;
        @(negedge clk);
        chk("err_sticky_after_done", int'(ba.err), 1);
        chk("idle_busy", int'(ba.busy), 0);
        tick(1);
        // Write beat never acknowledged: timeout after 15 cycles.
        ack_a = 1'b0;
        go(0, 8'h30, 8'h11, s);
        for (int k = 0; k < 15; k++) push(0, K_WR, s + 1 + k, 8'h30, 8'h11);
        push(0, K_DONE, s + 16, 8'h00, 8'h01);
        @(negedge clk);
        chk("err_cleared_on_accept", int'(ba.err), 0);
        chk("busy_during_timeout", int'(ba.busy), 1);
        tick(20);
        ack_a = 1'b1;
        // Start held high for three cycles: one burst only.
        s = cyc;
        ba.start = 1'b1;
        ba.base_addr = 8'h50;
        ba.seed = 8'h60;
        push(0, K_WR, s + 1, 8'h50, 8'h60);
        push(0, K_RD, s + 2, 8'h50, 8'h00);
        push(0, K_RD, s + 3, 8'h50, 8'h00);
        push(0, K_DONE, s + 4, 8'h00, 8'h00);
        tick(3);
        ba.start = 1'b0;
        tick(8);
        // Fresh rise while the burst is reading is ignored.
        go(0, 8'h58, 8'h70, s);
        push(0, K_WR, s + 1, 8'h58, 8'h70);
        push(0, K_RD, s + 2, 8'h58, 8'h00);
        push(0, K_RD, s + 3, 8'h58, 8'h00);
        push(0, K_DONE, s + 4, 8'h00, 8'h00);
        tick(1);
        ba.start = 1'b1;
        ba.base_addr = 8'h99;
        tick(1);
        ba.start = 1'b0;
        tick(8);
        // Reset during the first read, then a start in the first cycle after reset.
        go(0, 8'h40, 8'h3C, s);
        push(0, K_WR, s + 1, 8'h40, 8'h3C);
        push(0, K_RD, s + 2, 8'h40, 8'h00);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        s = cyc;
        ba.start = 1'b1;
        ba.base_addr = 8'h44;
        ba.seed = 8'h5A;
        push(0, K_WR, s + 1, 8'h44, 8'h5A);
        push(0, K_RD, s + 2, 8'h44, 8'h00);
        push(0, K_RD, s + 3, 8'h44, 8'h00);
        push(0, K_DONE, s + 4, 8'h00, 8'h00);
        @(negedge clk);
        chk("rst_mid_rd", int'(ba.rd), 0);
        chk("rst_mid_wr", int'(ba.wr), 0);
        chk("rst_mid_busy", int'(ba.busy), 0);
        chk("rst_mid_done", int'(ba.done), 0);
        tick(1);
        ba.start = 1'b0;
        tick(10);
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
